wbu: RTL and testbench

- Write-back stage directly downstream of the load/store stage.
- Accepts one retired instruction per handshake: writeback value, CSR writeback value, destination indices, write enables and the ecall flag.
- Commits them into the architectural GPR file and the four-entry machine CSR bank.
- Then signals the fetch stage that the instruction has retired, supplying a redirect target when the instruction was an ecall.
- Provides combinational read ports for decode.

---
 rtl/wbu_pkg.sv | 10 +
 rtl/wbu_gpr_file.sv | 23 ++
 rtl/wbu.sv | 113 +++++++++++
 tb/tb_wbu.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/wbu_pkg.sv
// wbu_pkg: shared constants and state encoding for the write-back unit
package wbu_pkg;
  localparam logic [1:0] CSR_MSTATUS = 2'd0;
  localparam logic [1:0] CSR_MTVEC   = 2'd1;
  localparam logic [1:0] CSR_MEPC    = 2'd2;
  localparam logic [1:0] CSR_MCAUSE  = 2'd3;
  localparam logic [31:0] ECALL_CAUSE_DEF = 32'd11;
  localparam logic [31:0] MSTATUS_RST_DEF = 32'h0000_1800;
  typedef enum logic [1:0] {IDLE, COMMIT, SEND} state_e;
endpackage

// File: rtl/wbu_gpr_file.sv
// gpr_file: architectural GPRs, one write port, two combinational read ports, x0 reads zero
module gpr_file #(
  parameter int XLEN   = 32,
  parameter int NR_GPR = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);
  logic [XLEN-1:0] regs_q [NR_GPR];
  always_ff @(posedge clk) begin
    if (!rst) regs_q <= '{default: '0};
    else if (we_i && waddr_i != 5'd0) regs_q[waddr_i] <= wdata_i;
  end
  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/wbu.sv
// wbu: write-back stage committing GPR/CSR results and signalling retire to fetch
module wbu
  import wbu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NR_GPR      = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = MSTATUS_RST_DEF,
  parameter logic [XLEN-1:0] ECALL_CAUSE = ECALL_CAUSE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wbu_receive_valid,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] csr_wd,
  input  logic [4:0]      rd,
  input  logic [1:0]      csr_rd,
  input  logic            reg_write_en,
  input  logic            csreg_write_en,
  input  logic            ecall,
  output logic            wbu_receive_ready,
  output logic            wbu_send_valid,
  input  logic            wbu_send_ready,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic [1:0]      csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] mtvec_out
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] wd_q, csr_wd_q, redirect_pc_q;
  logic [4:0]      rd_q;
  logic [1:0]      csr_rd_q;
  logic            rwe_q, cwe_q, ecall_q, send_valid_q, redirect_q;
  logic [XLEN-1:0] csr_q [4];
  logic            accept, commit;

  assign accept = state_q == IDLE && wbu_receive_valid;
  assign commit = state_q == COMMIT;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = wbu_receive_valid ? COMMIT : IDLE;
      COMMIT:  state_d = SEND;
      SEND:    state_d = wbu_send_ready ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // ecall's mcause update is placed after the generic CSR write so it wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      csr_wd_q      <= '0;
      rd_q          <= '0;
      csr_rd_q      <= '0;
      rwe_q         <= 1'b0;
      cwe_q         <= 1'b0;
      ecall_q       <= 1'b0;
      csr_q         <= '{MSTATUS_RST, '0, '0, '0};
      send_valid_q  <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wd_q     <= wd;
        csr_wd_q <= csr_wd;
        rd_q     <= rd;
        csr_rd_q <= csr_rd;
        rwe_q    <= reg_write_en;
        cwe_q    <= csreg_write_en;
        ecall_q  <= ecall;
      end
      if (commit) begin
        if (cwe_q) csr_q[csr_rd_q] <= csr_wd_q;
        if (ecall_q) begin
          csr_q[CSR_MCAUSE] <= ECALL_CAUSE;
          redirect_pc_q     <= csr_q[CSR_MTVEC];
        end
        redirect_q   <= ecall_q;
        send_valid_q <= 1'b1;
      end else if (state_q == SEND && wbu_send_ready) begin
        send_valid_q <= 1'b0;
        redirect_q   <= 1'b0;
      end
    end
  end

  gpr_file #(.XLEN(XLEN), .NR_GPR(NR_GPR)) u_gpr (
    .clk      (clk),
    .rst      (rst),
    .we_i     (commit && rwe_q),
    .waddr_i  (rd_q),
    .wdata_i  (wd_q),
    .raddr1_i (raddr1),
    .raddr2_i (raddr2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign wbu_receive_ready = state_q == IDLE;
  assign wbu_send_valid    = send_valid_q;
  assign redirect          = redirect_q;
  assign redirect_pc       = redirect_pc_q;
  assign csr_rdata         = csr_q[csr_raddr];
  assign mtvec_out         = csr_q[CSR_MTVEC];
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: table vectors, hand sequences and randomized transactions against a reference model
module tb_wbu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wbu_receive_valid = 1'b0;
  logic [31:0] wd = '0, csr_wd = '0;
  logic [4:0]  rd = '0;
  logic [1:0]  csr_rd = '0;
  logic        reg_write_en = 1'b0, csreg_write_en = 1'b0, ecall = 1'b0;
  logic        wbu_receive_ready, wbu_send_valid, redirect;
  logic        wbu_send_ready = 1'b0;
  logic [31:0] redirect_pc, rdata1, rdata2, csr_rdata, mtvec_out;
  logic [4:0]  raddr1 = '0, raddr2 = '0;
  logic [1:0]  csr_raddr = '0;

  wbu dut (
    .clk(clk), .rst(rst), .wbu_receive_valid(wbu_receive_valid), .wd(wd), .csr_wd(csr_wd),
    .rd(rd), .csr_rd(csr_rd), .reg_write_en(reg_write_en), .csreg_write_en(csreg_write_en),
    .ecall(ecall), .wbu_receive_ready(wbu_receive_ready), .wbu_send_valid(wbu_send_valid),
    .wbu_send_ready(wbu_send_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .mtvec_out(mtvec_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic [31:0] gm [32];
  logic [31:0] cm [4];
  logic [31:0] last_pc;

  typedef struct {
    logic [4:0] rd; logic [31:0] wd; logic [1:0] crd; logic [31:0] cwd;
    logic rwe; logic cwe; logic ec; int hold;
    logic [4:0] ga; logic [31:0] gexp; logic [1:0] ca; logic [31:0] cexp;
    logic rexp; logic [31:0] pcexp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (gm[i]) gm[i] = '0;
    cm[0] = 32'h0000_1800; cm[1] = '0; cm[2] = '0; cm[3] = '0;
    last_pc = '0;
  endtask

  task automatic txn(input logic [4:0] rd_v, input logic [31:0] wd_v, input logic [1:0] crd,
                     input logic [31:0] cwd, input logic rwe, input logic cwe, input logic ec,
                     input int hold, output logic r_redir, output logic [31:0] r_pc);
    chk("idle_rx_ready", wbu_receive_ready, 1);
    wbu_receive_valid = 1; rd = rd_v; wd = wd_v; csr_rd = crd; csr_wd = cwd;
    reg_write_en = rwe; csreg_write_en = cwe; ecall = ec; wbu_send_ready = (hold == 0);
    @(posedge clk); #1;
    wbu_receive_valid = 0; wd = $urandom; csr_wd = $urandom; rd = 5'($urandom);
    chk("commit_rx_ready", wbu_receive_ready, 0);
    chk("commit_send_valid", wbu_send_valid, 0);
    if (ec) last_pc = cm[1];
    if (rwe && rd_v != 0) gm[rd_v] = wd_v;
    if (cwe) cm[crd] = cwd;
    if (ec) cm[3] = 32'd11;
    @(posedge clk); #1;
    chk("send_valid", wbu_send_valid, 1);
    chk("redirect", redirect, ec);
    chk("redirect_pc", redirect_pc, last_pc);
    r_redir = redirect; r_pc = redirect_pc;
    raddr1 = rd_v; raddr2 = 5'($urandom); csr_raddr = crd; #1;
    chk("rdata1", rdata1, gm[rd_v]);
    chk("rdata2", rdata2, gm[raddr2]);
    chk("csr_rdata", csr_rdata, cm[crd]);
    chk("mtvec_out", mtvec_out, cm[1]);
    for (int i = 0; i < hold; i++) begin
      wbu_receive_valid = 1; rd = 5'($urandom); wd = $urandom; reg_write_en = 1;
      ecall = 1; csr_wd = $urandom; csreg_write_en = 1;
      @(posedge clk); #1;
      chk("bp_send_valid", wbu_send_valid, 1);
      chk("bp_redirect", redirect, r_redir);
      chk("bp_redirect_pc", redirect_pc, r_pc);
      chk("bp_rx_ready", wbu_receive_ready, 0);
    end
    wbu_receive_valid = 0; wbu_send_ready = 1;
    @(posedge clk); #1;
    chk("acc_send_valid", wbu_send_valid, 0);
    chk("acc_redirect", redirect, 0);
    chk("acc_rx_ready", wbu_receive_ready, 1);
  endtask

  logic        r_redir;
  logic [31:0] r_pc;

  initial begin
    tbl[0] = '{5'd5,  32'hDEADBEEF, 2'd0, 32'h0,        1, 0, 0, 0, 5'd5,  32'hDEADBEEF, 2'd0, 32'h0000_1800, 0, 32'h0};
    tbl[1] = '{5'd0,  32'h0000_1234, 2'd0, 32'h0,       1, 0, 0, 0, 5'd0,  32'h0,        2'd0, 32'h0000_1800, 0, 32'h0};
    tbl[2] = '{5'd3,  32'h0,        2'd1, 32'h8000_0100, 0, 1, 0, 1, 5'd5,  32'hDEADBEEF, 2'd1, 32'h8000_0100, 0, 32'h0};
    tbl[3] = '{5'd4,  32'h0,        2'd2, 32'h8000_0040, 0, 1, 1, 4, 5'd4,  32'h0,        2'd2, 32'h8000_0040, 1, 32'h8000_0100};
    tbl[4] = '{5'd6,  32'h0,        2'd3, 32'h0,        0, 0, 0, 0, 5'd6,  32'h0,        2'd3, 32'd11,        0, 32'h8000_0100};
    tbl[5] = '{5'd6,  32'h0,        2'd3, 32'h55,       0, 1, 1, 0, 5'd5,  32'hDEADBEEF, 2'd3, 32'd11,        1, 32'h8000_0100};
    tbl[6] = '{5'd6,  32'h0,        2'd1, 32'h9000_0000, 0, 1, 1, 2, 5'd5, 32'hDEADBEEF, 2'd1, 32'h9000_0000, 1, 32'h8000_0100};
    tbl[7] = '{5'd31, 32'h0000_A5A5, 2'd0, 32'h0,       1, 1, 0, 2, 5'd31, 32'h0000_A5A5, 2'd0, 32'h0,         0, 32'h8000_0100};
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
      chk("rst_rdata1", rdata1, 0);
      chk("rst_rdata2", rdata2, 0);
    end
    for (int c = 0; c < 4; c++) begin
      csr_raddr = 2'(c); #1;
      chk("rst_csr", csr_rdata, cm[c]);
    end
    chk("rst_mtvec", mtvec_out, 0);
    chk("rst_send_valid", wbu_send_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_redirect_pc", redirect_pc, 0);

    foreach (tbl[k]) begin
      txn(tbl[k].rd, tbl[k].wd, tbl[k].crd, tbl[k].cwd, tbl[k].rwe, tbl[k].cwe, tbl[k].ec,
          tbl[k].hold, r_redir, r_pc);
      chk("tbl_redirect", r_redir, tbl[k].rexp);
      chk("tbl_redirect_pc", r_pc, tbl[k].pcexp);
      raddr1 = tbl[k].ga; csr_raddr = tbl[k].ca; #1;
      chk("tbl_gpr", rdata1, tbl[k].gexp);
      chk("tbl_csr", csr_rdata, tbl[k].cexp);
    end

    // reset while a GPR write sits in COMMIT
    wbu_receive_valid = 1; rd = 5'd7; wd = 32'hCAFE_0007; reg_write_en = 1; csreg_write_en = 0; ecall = 0;
    @(posedge clk); #1;
    wbu_receive_valid = 0; rst = 0;
    @(posedge clk); #1;
    rst = 1; model_reset();
    raddr1 = 5'd7; csr_raddr = 2'd0; #1;
    chk("midrst_x7", rdata1, 0);
    chk("midrst_send_valid", wbu_send_valid, 0);
    chk("midrst_rx_ready", wbu_receive_ready, 1);
    chk("midrst_mstatus", csr_rdata, 32'h0000_1800);

    // reset while an ecall retire is held in SEND
    txn(5'd0, 32'h0, 2'd1, 32'h4000_0000, 0, 1, 0, 0, r_redir, r_pc);
    wbu_receive_valid = 1; ecall = 1; csreg_write_en = 0; reg_write_en = 0; wbu_send_ready = 0;
    @(posedge clk); #1;
    wbu_receive_valid = 0;
    @(posedge clk); #1;
    chk("sendrst_pre_redirect", redirect, 1);
    chk("sendrst_pre_pc", redirect_pc, 32'h4000_0000);
    rst = 0;
    @(posedge clk); #1;
    rst = 1; model_reset();
    chk("sendrst_redirect", redirect, 0);
    chk("sendrst_pc", redirect_pc, 0);
    chk("sendrst_send_valid", wbu_send_valid, 0);
    chk("sendrst_mtvec", mtvec_out, 0);

    for (int n = 0; n < 60; n++)
      txn(5'($urandom), $urandom, 2'($urandom), $urandom, 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0), $urandom_range(0, 3), r_redir, r_pc);

    for (int a = 0; a < 32; a++) begin
      raddr2 = 5'(a); #1;
      chk("final_gpr", rdata2, gm[a]);
    end
    for (int c = 0; c < 4; c++) begin
      csr_raddr = 2'(c); #1;
      chk("final_csr", csr_rdata, cm[c]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
